// File: rtl/coin_acceptor.sv
// Coin sensor front end: synchronises and debounces the 5rs/10rs sensors, then emits
// one registered coin code (or reject) per coin, followed by a release wait and a lockout gap.
module coin_acceptor #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int LOCKOUT_CYCLES  = 8,
   parameter int CNT_W           = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       coin5_raw,
   input  logic       coin10_raw,
   input  logic       enable,
   output logic [1:0] coin_code,
   output logic       reject,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, DEBOUNCE, WAIT_RELEASE, LOCKOUT} state_t;

   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             type10, type10_nxt;
   logic [1:0]       code_nxt;
   logic             reject_nxt;
   logic             s5_meta, s5, s10_meta, s10;
   logic             latched, other;

   always_ff @(posedge clk) begin
      if (reset) begin
         s5_meta  <= 1'b0;
         s5       <= 1'b0;
         s10_meta <= 1'b0;
         s10      <= 1'b0;
      end else begin
         s5_meta  <= coin5_raw;
         s5       <= s5_meta;
         s10_meta <= coin10_raw;
         s10      <= s10_meta;
      end
   end

   // Coming out of reset in WAIT_RELEASE means a sensor held through reset is never credited.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= WAIT_RELEASE;
         cnt       <= '0;
         type10    <= 1'b0;
         coin_code <= 2'b00;
         reject    <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         type10    <= type10_nxt;
         coin_code <= code_nxt;
         reject    <= reject_nxt;
      end
   end

   assign latched = type10 ? s10 : s5;
   assign other   = type10 ? s5  : s10;

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      type10_nxt = type10;
      code_nxt   = 2'b00;
      reject_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (s5 && s10) begin
               reject_nxt = 1'b1;
               cnt_nxt    = '0;
               state_nxt  = WAIT_RELEASE;
            end else if (s5 || s10) begin
               type10_nxt = s10;
               cnt_nxt    = CNT_W'(1);
               state_nxt  = DEBOUNCE;
            end
         end
         DEBOUNCE: begin
            if (!latched) begin
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end else if (other) begin
               reject_nxt = 1'b1;
               cnt_nxt    = '0;
               state_nxt  = WAIT_RELEASE;
            end else if (cnt == DEB_LAST) begin
               if (enable) code_nxt = type10 ? 2'b10 : 2'b01;
               else        reject_nxt = 1'b1;
               cnt_nxt   = '0;
               state_nxt = WAIT_RELEASE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         WAIT_RELEASE: begin
            if (s5 || s10) begin
               cnt_nxt = '0;
            end else if (cnt == DEB_LAST) begin
               cnt_nxt   = '0;
               state_nxt = LOCKOUT;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         LOCKOUT: begin
            if (cnt == LOCK_LAST) begin
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = WAIT_RELEASE;
         end
      endcase
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: expected pulses (code, reject, cycle) are queued
// when a coin is driven and matched against the outputs sampled on each falling edge.
module tb_coin_acceptor;

   localparam int DEB  = 4;
   localparam int LOCK = 8;

   typedef struct {
      logic [1:0] code;
      logic       rej;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       coin5_raw = 1'b0;
   logic       coin10_raw = 1'b0;
   logic       enable = 1'b1;
   logic [1:0] coin_code;
   logic       reject;
   logic       busy;

   int   cyc = 0;
   int   n_run = 0;
   int   n_fail = 0;
   exp_t sb[$];

   coin_acceptor #(.DEBOUNCE_CYCLES(DEB), .LOCKOUT_CYCLES(LOCK), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .coin5_raw(coin5_raw), .coin10_raw(coin10_raw),
      .enable(enable), .coin_code(coin_code), .reject(reject), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL timeout: run did not finish (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

   // Advance to the next falling edge and reconcile outputs with the scoreboard.
   task automatic step();
      exp_t e;
      @(negedge clk);
      n_run++;
      if (coin_code !== 2'b00 && reject !== 1'b0) begin
         n_fail++;
         $display("FAIL exclusive: coin_code=%b reject=%b at cycle %0d, required one of them 0", coin_code, reject, cyc);
      end
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
         e = sb.pop_front();
         n_run++;
         n_fail++;
         $display("FAIL missed_pulse: no pulse at cycle %0d, required code=%b reject=%b", e.cyc, e.code, e.rej);
      end
      if (coin_code !== 2'b00 || reject !== 1'b0) begin
         n_run++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse: code=%b reject=%b at cycle %0d, required none", coin_code, reject, cyc);
         end else begin
            e = sb.pop_front();
            if (coin_code !== e.code || reject !== e.rej || cyc !== e.cyc) begin
               n_fail++;
               $display("FAIL pulse: code=%b reject=%b cycle=%0d, required code=%b reject=%b cycle=%0d",
                        coin_code, reject, cyc, e.code, e.rej, e.cyc);
            end
         end
      end
   endtask

   task automatic wait_idle(input int max_cycles, output int at);
      at = -1;
      for (int i = 0; i < max_cycles; i++) begin
         step();
         if (busy === 1'b0) begin
            at = cyc;
            break;
         end
      end
   endtask

   task automatic test_reset();
      int at, rel;
      reset = 1'b1;
      repeat (3) step();
      n_run++;
      if (coin_code !== 2'b00 || reject !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_state: code=%b reject=%b busy=%b, required 00/0/1", coin_code, reject, busy);
      end
      reset = 1'b0;
      rel = cyc;
      wait_idle(40, at);
      n_run++;
      if (at !== rel + DEB + LOCK) begin
         n_fail++;
         $display("FAIL reset_idle: idle at cycle %0d, required %0d", at, rel + DEB + LOCK);
      end
   endtask

   task automatic test_coin5();
      int at, rel;
      sb.push_back('{2'b01, 1'b0, cyc + DEB + 2});
      coin5_raw = 1'b1;
      repeat (6) step();
      coin5_raw = 1'b0;
      rel = cyc;
      wait_idle(40, at);
      n_run++;
      if (at !== rel + 2 + DEB + LOCK) begin
         n_fail++;
         $display("FAIL coin5_idle: idle at cycle %0d, required %0d", at, rel + 2 + DEB + LOCK);
      end
      n_run++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL coin5_pending: %0d pulses outstanding, required 0", sb.size());
      end
      sb.delete();
   endtask

   // enable dips low mid-debounce but is high at the accept edge, so the coin is credited.
   task automatic test_coin10();
      int at, rel;
      sb.push_back('{2'b10, 1'b0, cyc + DEB + 2});
      coin10_raw = 1'b1;
      repeat (2) step();
      enable = 1'b0;
      step();
      enable = 1'b1;
      repeat (3) step();
      coin10_raw = 1'b0;
      rel = cyc;
      wait_idle(40, at);
      n_run++;
      if (at !== rel + 2 + DEB + LOCK) begin
         n_fail++;
         $display("FAIL coin10_idle: idle at cycle %0d, required %0d", at, rel + 2 + DEB + LOCK);
      end
      n_run++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL coin10_pending: %0d pulses outstanding, required 0", sb.size());
      end
      sb.delete();
   endtask

   task automatic test_glitch();
      int at, c;
      c = cyc;
      coin5_raw = 1'b1;
      repeat (2) step();
      coin5_raw = 1'b0;
      step();
      n_run++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL glitch_debounce: busy=%b, required 1", busy);
      end
      wait_idle(20, at);
      n_run++;
      if (at !== c + 5) begin
         n_fail++;
         $display("FAIL glitch_idle: idle at cycle %0d, required %0d", at, c + 5);
      end
      repeat (4) step();
      n_run++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL glitch_stay_idle: busy=%b, required 0", busy);
      end
   endtask

   task automatic test_both();
      int at, rel;
      sb.push_back('{2'b00, 1'b1, cyc + 3});
      coin5_raw  = 1'b1;
      coin10_raw = 1'b1;
      repeat (6) step();
      coin5_raw  = 1'b0;
      coin10_raw = 1'b0;
      rel = cyc;
      wait_idle(40, at);
      n_run++;
      if (at !== rel + 2 + DEB + LOCK) begin
         n_fail++;
         $display("FAIL both_idle: idle at cycle %0d, required %0d", at, rel + 2 + DEB + LOCK);
      end
      n_run++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL both_pending: %0d pulses outstanding, required 0", sb.size());
      end
      sb.delete();
   endtask

   task automatic test_disabled();
      int at, rel;
      enable = 1'b0;
      sb.push_back('{2'b00, 1'b1, cyc + DEB + 2});
      coin5_raw = 1'b1;
      repeat (6) step();
      coin5_raw = 1'b0;
      enable = 1'b1;
      rel = cyc;
      wait_idle(40, at);
      n_run++;
      if (at !== rel + 2 + DEB + LOCK) begin
         n_fail++;
         $display("FAIL disabled_idle: idle at cycle %0d, required %0d", at, rel + 2 + DEB + LOCK);
      end
      n_run++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL disabled_pending: %0d pulses outstanding, required 0", sb.size());
      end
      sb.delete();
   endtask

   task automatic test_reset_mid_debounce();
      int at, rel;
      coin5_raw = 1'b1;
      repeat (4) step();
      reset = 1'b1;
      repeat (2) step();
      n_run++;
      if (coin_code !== 2'b00 || reject !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL midreset_state: code=%b reject=%b busy=%b, required 00/0/1", coin_code, reject, busy);
      end
      reset = 1'b0;
      repeat (6) step();
      n_run++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL midreset_held: busy=%b, required 1", busy);
      end
      coin5_raw = 1'b0;
      rel = cyc;
      wait_idle(40, at);
      n_run++;
      if (at !== rel + 2 + DEB + LOCK) begin
         n_fail++;
         $display("FAIL midreset_idle: idle at cycle %0d, required %0d", at, rel + 2 + DEB + LOCK);
      end
      sb.push_back('{2'b01, 1'b0, cyc + DEB + 2});
      coin5_raw = 1'b1;
      repeat (6) step();
      coin5_raw = 1'b0;
      wait_idle(40, at);
      n_run++;
      if (sb.size() != 0 || at < 0) begin
         n_fail++;
         $display("FAIL midreset_next_coin: %0d pulses outstanding, idle at %0d, required 0 and idle", sb.size(), at);
      end
      sb.delete();
   endtask

   initial begin
      test_reset();
      test_coin5();
      test_coin10();
      test_glitch();
      test_both();
      test_disabled();
      test_reset_mid_debounce();
      repeat (3) step();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
